// File: rtl/y86_pkg.sv
// Shared Y86 definitions: instruction codes, status encodings and the
// sequential controller state enumeration. Optional macro SEQ_STEP_EN adds
// the single-step PAUSE state.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [1:0] {
    STAT_AOK = 2'd0,
    STAT_HLT = 2'd1,
    STAT_ADR = 2'd2,
    STAT_INS = 2'd3
  } stat_e;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_EXECUTE   = 4'd3,
    S_MEMORY    = 4'd4,
    S_WRITEBACK = 4'd5,
    S_PCUPD     = 4'd6,
    S_HALT      = 4'd7
`ifdef SEQ_STEP_EN
    ,
    S_PAUSE     = 4'd8
`endif
  } state_e;

  // Instructions that touch data memory in the MEMORY stage.
  function automatic logic is_mem_icode(input logic [3:0] code);
    logic r;
    case (code)
      I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: r = 1'b1;
      default:                                            r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seq_mem_timer.sv
// Data-memory timeout counter. Counts consecutive enabled cycles; o_expired
// is high during the last allowed cycle (MEM_TIMEOUT-th enabled cycle).
module seq_mem_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam int W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

  logic [W-1:0] r_count;

  // Count elapsed wait cycles, holding at the final value.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_en && !o_expired) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_expired = (r_count == LAST);

endmodule

// File: rtl/seq_controller.sv
// Multi-cycle Y86 sequencer: FETCH..PCUPD stage enables, data-memory
// handshake with timeout, status reporting and retired-instruction count.
// Optional macro SEQ_STEP_EN adds the step input and PAUSE state.
module seq_controller
  import y86_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic             imem_err,
  input  logic             dmem_ack,
  input  logic             dmem_err,
`ifdef SEQ_STEP_EN
  input  logic             step,
`endif
  output logic             f_en,
  output logic             d_en,
  output logic             e_en,
  output logic             m_en,
  output logic             w_en,
  output logic             pc_en,
  output logic             dmem_req,
  output logic [1:0]       stat,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  state_e           r_state;
  state_e           w_next;
  stat_e            r_stat;
  stat_e            w_stat_next;
  logic [3:0]       r_icode;
  logic [CNT_W-1:0] r_retired;
  logic             w_mem_req;
  logic             w_expired;

  seq_mem_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_clear   (!w_mem_req),
    .i_en      (w_mem_req),
    .o_expired (w_expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Status, latched instruction code and retired counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat    <= STAT_AOK;
      r_icode   <= '0;
      r_retired <= '0;
    end else begin
      r_stat <= w_stat_next;
      if (r_state == S_FETCH) begin
        r_icode <= icode;
      end
      if (r_state == S_PCUPD) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  // Next-state, status update and stage enables.
  always_comb begin
    w_next      = r_state;
    w_stat_next = r_stat;
    w_mem_req   = 1'b0;
    f_en        = 1'b0;
    d_en        = 1'b0;
    e_en        = 1'b0;
    m_en        = 1'b0;
    w_en        = 1'b0;
    pc_en       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_FETCH;
      end
      S_FETCH: begin
        f_en = 1'b1;
        if (imem_err) begin
          w_next      = S_HALT;
          w_stat_next = STAT_ADR;
        end else if (icode > I_POPQ) begin
          w_next      = S_HALT;
          w_stat_next = STAT_INS;
        end else if (icode == I_HALT) begin
          w_next      = S_HALT;
          w_stat_next = STAT_HLT;
        end else begin
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        d_en   = 1'b1;
        w_next = S_EXECUTE;
      end
      S_EXECUTE: begin
        e_en   = 1'b1;
        w_next = S_MEMORY;
      end
      S_MEMORY: begin
        m_en = 1'b1;
        if (is_mem_icode(r_icode)) begin
          w_mem_req = 1'b1;
          // An ack on the final allowed cycle takes precedence over expiry.
          if (dmem_ack) begin
            if (dmem_err) begin
              w_next      = S_HALT;
              w_stat_next = STAT_ADR;
            end else begin
              w_next = S_WRITEBACK;
            end
          end else if (w_expired) begin
            w_next      = S_HALT;
            w_stat_next = STAT_ADR;
          end
        end else begin
          w_next = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        w_en   = 1'b1;
        w_next = S_PCUPD;
      end
      S_PCUPD: begin
        pc_en = 1'b1;
`ifdef SEQ_STEP_EN
        w_next = S_PAUSE;
`else
        w_next = S_FETCH;
`endif
      end
`ifdef SEQ_STEP_EN
      S_PAUSE: begin
        if (step) w_next = S_FETCH;
      end
`endif
      S_HALT: begin
        w_next = S_HALT;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign dmem_req = w_mem_req;
  assign halted   = (r_state == S_HALT);
  assign stat     = r_stat;
  assign retired  = r_retired;

endmodule

// File: tb/tb_seq_controller.sv
// Self-checking bench for seq_controller: per-cycle expected outputs are
// queued when stimulus is launched and popped at each falling edge.
`timescale 1ns/1ps
module tb_seq_controller;
  import y86_pkg::*;

  localparam int MEM_TIMEOUT = 16;

  typedef struct packed {
    logic [5:0]  en;
    logic        req;
    logic        hlt;
    logic [1:0]  st;
    logic [31:0] ret;
  } exp_t;

  localparam logic [5:0] EN_F = 6'b100000;
  localparam logic [5:0] EN_D = 6'b010000;
  localparam logic [5:0] EN_E = 6'b001000;
  localparam logic [5:0] EN_M = 6'b000100;
  localparam logic [5:0] EN_W = 6'b000010;
  localparam logic [5:0] EN_P = 6'b000001;
  localparam logic [5:0] EN_0 = 6'b000000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  icode = 4'h0;
  logic        imem_err = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        dmem_err = 1'b0;
`ifdef SEQ_STEP_EN
  logic        step = 1'b0;
`endif
  logic        f_en, d_en, e_en, m_en, w_en, pc_en, dmem_req, halted;
  logic [1:0]  stat;
  logic [31:0] retired;
  logic        n_f, n_d, n_e, n_m, n_w, n_pc, n_req, n_halted;
  logic [1:0]  n_stat;
  logic [1:0]  n_retired;

  int checks = 0;
  int failures = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  seq_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .start(start), .icode(icode),
    .imem_err(imem_err), .dmem_ack(dmem_ack), .dmem_err(dmem_err),
`ifdef SEQ_STEP_EN
    .step(step),
`endif
    .f_en(f_en), .d_en(d_en), .e_en(e_en), .m_en(m_en), .w_en(w_en),
    .pc_en(pc_en), .dmem_req(dmem_req), .stat(stat), .halted(halted),
    .retired(retired)
  );

  // Narrow counter copy to exercise retired wrap-around.
  seq_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(2)) u_dut_narrow (
    .clk(clk), .reset(reset), .start(start), .icode(icode),
    .imem_err(imem_err), .dmem_ack(dmem_ack), .dmem_err(dmem_err),
`ifdef SEQ_STEP_EN
    .step(step),
`endif
    .f_en(n_f), .d_en(n_d), .e_en(n_e), .m_en(n_m), .w_en(n_w),
    .pc_en(n_pc), .dmem_req(n_req), .stat(n_stat), .halted(n_halted),
    .retired(n_retired)
  );

  function automatic exp_t ev(input logic [5:0] en, input logic req,
                              input logic h, input logic [1:0] st,
                              input logic [31:0] ret);
    exp_t e;
    e.en = en; e.req = req; e.hlt = h; e.st = st; e.ret = ret;
    return e;
  endfunction

  function automatic exp_t obs();
    return ev({f_en, d_en, e_en, m_en, w_en, pc_en}, dmem_req, halted, stat, retired);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; imem_err = 1'b0; dmem_ack = 1'b0; dmem_err = 1'b0;
`ifdef SEQ_STEP_EN
    step = 1'b0;
`endif
    @(negedge clk);
    reset = 1'b0;
    q.delete();
  endtask

  task automatic test_reset();
    exp_t e, a;
    @(negedge clk);
    reset = 1'b1; start = 1'b1; icode = I_OPQ;
    for (int i = 0; i < 2; i++) q.push_back(ev(EN_0, 1'b0, 1'b0, STAT_AOK, 32'd0));
    q.push_back(ev(EN_0, 1'b0, 1'b0, STAT_AOK, 32'd0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e = q.pop_front(); a = obs();
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL reset[%0d] actual=%h expected=%h", i, a, e);
      end
      if (i == 1) begin reset = 1'b0; start = 1'b0; end
    end
  endtask

  task automatic test_opq();
    exp_t e, a;
    do_reset();
    start = 1'b1; icode = I_OPQ;
    q.push_back(ev(EN_F, 0, 0, STAT_AOK, 0));
    q.push_back(ev(EN_D, 0, 0, STAT_AOK, 0));
    q.push_back(ev(EN_E, 0, 0, STAT_AOK, 0));
    q.push_back(ev(EN_M, 0, 0, STAT_AOK, 0));
    q.push_back(ev(EN_W, 0, 0, STAT_AOK, 0));
    q.push_back(ev(EN_P, 0, 0, STAT_AOK, 0));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      e = q.pop_front(); a = obs();
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL opq[%0d] actual=%h expected=%h", i, a, e);
      end
      if (i == 0) start = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (retired !== 32'd1) begin
      failures++;
      $display("FAIL opq_retired actual=%0d expected=1", retired);
    end
  endtask

  task automatic test_mem_ack();
    exp_t e, a;
    do_reset();
    start = 1'b1; icode = I_MRMOVQ;
    q.push_back(ev(EN_F, 0, 0, STAT_AOK, 0));
    q.push_back(ev(EN_D, 0, 0, STAT_AOK, 0));
    q.push_back(ev(EN_E, 0, 0, STAT_AOK, 0));
    for (int i = 0; i < 3; i++) q.push_back(ev(EN_M, 1, 0, STAT_AOK, 0));
    q.push_back(ev(EN_W, 0, 0, STAT_AOK, 0));
    q.push_back(ev(EN_P, 0, 0, STAT_AOK, 0));
    q.push_back(ev(EN_F, 0, 0, STAT_AOK, 1));
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      e = q.pop_front(); a = obs();
`ifdef SEQ_STEP_EN
      if (i == 8) e.en = EN_0;
`endif
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL mem_ack[%0d] actual=%h expected=%h", i, a, e);
      end
      case (i)
        0: start = 1'b0;
        1: icode = I_OPQ;
        5: dmem_ack = 1'b1;
        6: dmem_ack = 1'b0;
        default: ;
      endcase
    end
  endtask

  task automatic test_timeout();
    exp_t e, a;
    do_reset();
    start = 1'b1; icode = I_PUSHQ;
    q.push_back(ev(EN_F, 0, 0, STAT_AOK, 0));
    q.push_back(ev(EN_D, 0, 0, STAT_AOK, 0));
    q.push_back(ev(EN_E, 0, 0, STAT_AOK, 0));
    for (int i = 0; i < MEM_TIMEOUT; i++) q.push_back(ev(EN_M, 1, 0, STAT_AOK, 0));
    for (int i = 0; i < 4; i++) q.push_back(ev(EN_0, 0, 1, STAT_ADR, 0));
    for (int i = 0; i < 3 + MEM_TIMEOUT + 4; i++) begin
      @(negedge clk);
      e = q.pop_front(); a = obs();
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL timeout[%0d] actual=%h expected=%h", i, a, e);
      end
      if (i == 0) start = 1'b0;
      if (i == 3 + MEM_TIMEOUT) start = 1'b1;
      if (i == 4 + MEM_TIMEOUT) begin start = 1'b0; dmem_ack = 1'b1; end
      if (i == 5 + MEM_TIMEOUT) dmem_ack = 1'b0;
    end
  endtask

  task automatic test_ack_last();
    exp_t e, a;
    do_reset();
    start = 1'b1; icode = I_RMMOVQ;
    q.push_back(ev(EN_F, 0, 0, STAT_AOK, 0));
    q.push_back(ev(EN_D, 0, 0, STAT_AOK, 0));
    q.push_back(ev(EN_E, 0, 0, STAT_AOK, 0));
    for (int i = 0; i < MEM_TIMEOUT; i++) q.push_back(ev(EN_M, 1, 0, STAT_AOK, 0));
    q.push_back(ev(EN_W, 0, 0, STAT_AOK, 0));
    q.push_back(ev(EN_P, 0, 0, STAT_AOK, 0));
    for (int i = 0; i < MEM_TIMEOUT + 5; i++) begin
      @(negedge clk);
      e = q.pop_front(); a = obs();
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL ack_last[%0d] actual=%h expected=%h", i, a, e);
      end
      if (i == 0) start = 1'b0;
      if (i == MEM_TIMEOUT + 2) dmem_ack = 1'b1;
      if (i == MEM_TIMEOUT + 3) dmem_ack = 1'b0;
    end
  endtask

  task automatic test_ack_err();
    exp_t e, a;
    do_reset();
    start = 1'b1; icode = I_RET;
    q.push_back(ev(EN_F, 0, 0, STAT_AOK, 0));
    q.push_back(ev(EN_D, 0, 0, STAT_AOK, 0));
    q.push_back(ev(EN_E, 0, 0, STAT_AOK, 0));
    q.push_back(ev(EN_M, 1, 0, STAT_AOK, 0));
    q.push_back(ev(EN_0, 0, 1, STAT_ADR, 0));
    q.push_back(ev(EN_0, 0, 1, STAT_ADR, 0));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      e = q.pop_front(); a = obs();
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL ack_err[%0d] actual=%h expected=%h", i, a, e);
      end
      if (i == 0) start = 1'b0;
      if (i == 3) begin dmem_ack = 1'b1; dmem_err = 1'b1; end
      if (i == 4) begin dmem_ack = 1'b0; dmem_err = 1'b0; end
    end
  endtask

  task automatic test_fetch_errors();
    logic [3:0] codes [4] = '{4'hC, 4'h0, 4'h0, 4'hF};
    logic       ierrs [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0] stats [4] = '{STAT_INS, STAT_ADR, STAT_HLT, STAT_ADR};
    exp_t e, a;
    for (int t = 0; t < 4; t++) begin
      do_reset();
      start = 1'b1; icode = codes[t]; imem_err = ierrs[t];
      q.push_back(ev(EN_F, 0, 0, STAT_AOK, 0));
      q.push_back(ev(EN_0, 0, 1, stats[t], 0));
      q.push_back(ev(EN_0, 0, 1, stats[t], 0));
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        e = q.pop_front(); a = obs();
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL fetch_err%0d[%0d] actual=%h expected=%h", t, i, a, e);
        end
        if (i == 0) start = 1'b0;
        if (i == 1) begin imem_err = 1'b0; icode = I_OPQ; end
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    exp_t e, a;
    do_reset();
    start = 1'b1; icode = I_MRMOVQ;
    q.push_back(ev(EN_F, 0, 0, STAT_AOK, 0));
    q.push_back(ev(EN_D, 0, 0, STAT_AOK, 0));
    q.push_back(ev(EN_E, 0, 0, STAT_AOK, 0));
    q.push_back(ev(EN_M, 1, 0, STAT_AOK, 0));
    q.push_back(ev(EN_M, 1, 0, STAT_AOK, 0));
    for (int i = 0; i < 3; i++) q.push_back(ev(EN_0, 0, 0, STAT_AOK, 0));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      e = q.pop_front(); a = obs();
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL reset_mid_mem[%0d] actual=%h expected=%h", i, a, e);
      end
      case (i)
        0: start = 1'b0;
        4: reset = 1'b1;
        5: begin reset = 1'b0; dmem_ack = 1'b1; end
        6: dmem_ack = 1'b0;
        default: ;
      endcase
    end
  endtask

`ifndef SEQ_STEP_EN
  task automatic test_back_to_back();
    logic [5:0] stg [6] = '{EN_F, EN_D, EN_E, EN_M, EN_W, EN_P};
    logic [3:0] prog [6] = '{I_OPQ, I_NOP, I_RRMOVQ, I_IRMOVQ, I_JXX, I_HALT};
    exp_t e, a;
    do_reset();
    start = 1'b1; icode = prog[0];
    for (int i = 0; i < 30; i++) q.push_back(ev(stg[i % 6], 0, 0, STAT_AOK, 32'(i / 6)));
    q.push_back(ev(EN_F, 0, 0, STAT_AOK, 5));
    q.push_back(ev(EN_0, 0, 1, STAT_HLT, 5));
    q.push_back(ev(EN_0, 0, 1, STAT_HLT, 5));
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      e = q.pop_front(); a = obs();
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL b2b[%0d] actual=%h expected=%h", i, a, e);
      end
      if (i == 0) start = 1'b0;
      if (i % 6 == 1 && i / 6 < 5) icode = prog[i / 6 + 1];
    end
    checks++;
    if (n_retired !== 2'd1) begin
      failures++;
      $display("FAIL retired_wrap actual=%0d expected=1", n_retired);
    end
  endtask
`else
  task automatic test_step();
    logic [5:0] stg [6] = '{EN_F, EN_D, EN_E, EN_M, EN_W, EN_P};
    exp_t e, a;
    do_reset();
    start = 1'b1; icode = I_OPQ;
    for (int i = 0; i < 6; i++) q.push_back(ev(stg[i], 0, 0, STAT_AOK, 0));
    for (int i = 0; i < 3; i++) q.push_back(ev(EN_0, 0, 0, STAT_AOK, 1));
    for (int i = 0; i < 6; i++) q.push_back(ev(stg[i], 0, 0, STAT_AOK, 1));
    for (int i = 0; i < 3; i++) q.push_back(ev(EN_0, 0, 0, STAT_AOK, 2));
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      e = q.pop_front(); a = obs();
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL step[%0d] actual=%h expected=%h", i, a, e);
      end
      case (i)
        0: start = 1'b0;
        1: icode = I_NOP;
        6: start = 1'b1;
        7: start = 1'b0;
        8: step = 1'b1;
        9: step = 1'b0;
        default: ;
      endcase
    end
  endtask
`endif

  initial begin
    test_reset();
    test_opq();
    test_mem_ack();
    test_timeout();
    test_ack_last();
    test_ack_err();
    test_fetch_errors();
    test_reset_mid_mem();
`ifndef SEQ_STEP_EN
    test_back_to_back();
`else
    test_step();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_controller.md
SEQ_CONTROLLER -- requirements
Module: seq_controller

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16, max cycles to wait for dmem_ack before declaring ADR.
REQ-002 Parameter CNT_W, default 32, width of retired-instruction counter.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; leaves IDLE and begins fetch.
REQ-006 icode  input  4  instruction code from fetch, valid in FETCH.
REQ-007 imem_err  input  1  instruction-memory address error, sampled in FETCH.
REQ-008 dmem_ack  input  1  data-memory access complete.
REQ-009 dmem_err  input  1  data-memory address error; qualifies dmem_ack.
REQ-010 f_en, d_en, e_en, m_en, w_en, pc_en  output  1 each  one-hot stage enables.
REQ-011 dmem_req  output  1  data-memory request, held until ack, error or timeout.
REQ-012 stat  output  2  0=AOK, 1=HLT, 2=ADR, 3=INS.
REQ-013 halted  output  1  high in HALT state.
REQ-014 retired  output  CNT_W  count of completed instructions.

Function
REQ-015 States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT; exactly one stage enable high in FETCH..PCUPD, none in IDLE/HALT.
REQ-016 IDLE -> FETCH on start; start in any other state is ignored.
REQ-017 FETCH: imem_err -> HALT with stat=ADR; else icode > 4'hB -> HALT with stat=INS; else icode=4'h0 -> HALT with stat=HLT; else -> DECODE. imem_err has priority over INS, and INS over HLT.
REQ-018 DECODE -> EXECUTE -> MEMORY, one cycle each.
REQ-019 MEMORY for icodes 4,5,8,9,A,B asserts dmem_req; stays until dmem_ack or timeout; all other icodes spend one cycle in MEMORY with dmem_req low.
REQ-020 dmem_ack with dmem_err -> HALT with stat=ADR; dmem_ack without error -> WRITEBACK.
REQ-021 Timeout: after MEM_TIMEOUT consecutive MEMORY cycles without ack -> HALT with stat=ADR. Ack on the final allowed cycle wins over timeout.
REQ-022 WRITEBACK -> PCUPD -> FETCH, one cycle each. retired increments by 1 on leaving PCUPD and wraps modulo 2^CNT_W.
REQ-023 icode is latched in FETCH; later changes on the icode input have no effect until the next FETCH.
REQ-024 HALT is absorbing; only reset leaves it. stat and retired hold there.
REQ-025 Minimum latency per instruction is 6 cycles; a memory instruction takes 6+N-1 cycles, where N is the number of MEMORY cycles.

Reset
REQ-026 reset has priority over every input. Next state is IDLE; all enables, dmem_req and halted go to 0; stat=AOK; retired=0; timeout counter=0.
REQ-027 Reset during MEMORY drops dmem_req at that edge, and a late dmem_ack is ignored.

Configuration
REQ-028 Macro SEQ_STEP_EN. When defined: adds input step (1 bit) and state PAUSE. PCUPD goes to PAUSE instead of FETCH, and PAUSE goes to FETCH on a step pulse. All enables are low in PAUSE.
REQ-029 When SEQ_STEP_EN is not defined: no step port and no PAUSE state; PCUPD goes directly to FETCH.

Structure
REQ-030 Shared package y86_pkg holds the icode constants (HALT..POPQ), the stat encodings and the state enumeration, shared with the fetch and decode stages.
REQ-031 One sub-module, seq_mem_timer: a timeout counter with clear/enable and an expired output.

Verification
REQ-032 Reset, start, icode=4'h6 (OPQ): enables f,d,e,m,w,pc each high for 1 cycle in order; retired=1 after 6 cycles; dmem_req never high.
REQ-033 icode=4'h5, dmem_ack returned on the 3rd MEMORY cycle: dmem_req high for exactly 3 cycles, then WRITEBACK, stat=AOK.
REQ-034 icode=4'hA with no ack and MEM_TIMEOUT=16: dmem_req high for 16 cycles, then halted=1, stat=2.
REQ-035 FETCH with icode=4'hC -> stat=3. FETCH with imem_err=1 and icode=4'h0 -> stat=2. icode=4'h0 alone -> stat=1 and retired unchanged.
REQ-036 Reset asserted mid-MEMORY with ack arriving the next cycle: IDLE, dmem_req=0, retired=0, and the ack is ignored.
REQ-037 With SEQ_STEP_EN, two instructions: controller sits in PAUSE with enables low until step; retired increments once per step.
